// File: rtl/fpu_muldiv_seq.sv
// Iterative floating-point multiply/divide with round-to-nearest-even and flush-to-zero.
// Special operands bypass the datapath; normal operands take a fixed number of cycles.
module fpu_muldiv_seq #(
   parameter int EXP_W = 8,
   parameter int FRAC_W = 23,
   localparam int PRECISION = 1 + EXP_W + FRAC_W
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 Start,
   input  logic                 Operation,
   input  logic [PRECISION-1:0] A,
   input  logic [PRECISION-1:0] B,
   output logic                 Ready,
   output logic [PRECISION-1:0] Result,
   output logic [4:0]           Flags,
   output logic                 Done
);

   localparam int N  = FRAC_W + 1;
   localparam int QW = FRAC_W + 3;
   localparam int SW = EXP_W + 2;
   localparam int CW = $clog2(FRAC_W + 3);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ITER  = 3'd1;
   localparam logic [2:0] NORM  = 3'd2;
   localparam logic [2:0] ROUND = 3'd3;
   localparam logic [2:0] FIN   = 3'd4;

   localparam logic [CW-1:0] CNT_MUL = CW'(N - 1);
   localparam logic [CW-1:0] CNT_DIV = CW'(QW - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic signed [SW-1:0] BIAS_S     = SW'(2 ** (EXP_W - 1) - 1);
   localparam logic signed [SW-1:0] ALL_ONES_S = SW'(2 ** EXP_W - 1);
   localparam logic signed [SW-1:0] ONE_S      = SW'(1);
   localparam logic signed [SW-1:0] ZERO_S     = SW'(0);

   localparam logic [EXP_W-1:0]     EXP_ONES  = '1;
   localparam logic [FRAC_W-1:0]    FRAC_ZERO = '0;
   localparam logic [PRECISION-1:0] QNAN      = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

   logic [2:0]             state;
   logic                   op_q, sign_q;
   logic signed [SW-1:0]   exp_q;
   logic [N-1:0]           ma_q, mb_q, mant_q;
   logic [2*N-1:0]         prod;
   logic [N:0]             rem;
   logic [QW-1:0]          quo;
   logic [CW-1:0]          cnt;
   logic                   grd, rnd, stk;
   logic [PRECISION-1:0]   fin_res;
   logic [4:0]             fin_flags;

   logic [EXP_W-1:0]       ea, eb;
   logic [FRAC_W-1:0]      fa, fb;
   logic                   sign_in, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic signed [SW-1:0]   ea_s, eb_s, mul_exp, div_exp;
   logic [N:0]             mul_sum, rem_diff, rem_next;
   logic                   rem_ge;

   assign ea      = A[PRECISION-2:FRAC_W];
   assign eb      = B[PRECISION-2:FRAC_W];
   assign fa      = A[FRAC_W-1:0];
   assign fb      = B[FRAC_W-1:0];
   assign sign_in = A[PRECISION-1] ^ B[PRECISION-1];
   assign a_zero  = (ea == '0);
   assign b_zero  = (eb == '0);
   assign a_inf   = (&ea) && (fa == '0);
   assign b_inf   = (&eb) && (fb == '0);
   assign a_nan   = (&ea) && (fa != '0);
   assign b_nan   = (&eb) && (fb != '0);
   assign ea_s    = $signed({2'b00, ea});
   assign eb_s    = $signed({2'b00, eb});
   assign mul_exp = ea_s + eb_s - BIAS_S;
   assign div_exp = ea_s - eb_s + BIAS_S;

   assign mul_sum  = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, ma_q} : '0);
   assign rem_ge   = (rem >= {1'b0, mb_q});
   assign rem_diff = rem - {1'b0, mb_q};
   assign rem_next = (rem_ge ? rem_diff : rem) << 1;

   assign Ready = (state == IDLE);

   // Special operands resolve straight to a packed result; zeros here include flushed subnormals.
   logic                 special;
   logic [PRECISION-1:0] spec_res;
   logic [4:0]           spec_flags;

   always_comb begin
      special    = 1'b1;
      spec_res   = '0;
      spec_flags = '0;
      if (a_nan || b_nan) begin
         spec_res = QNAN;
      end else if (!Operation) begin
         if ((a_zero && b_inf) || (a_inf && b_zero)) begin
            spec_res   = QNAN;
            spec_flags = 5'b10000;
         end else if (a_inf || b_inf) begin
            spec_res = {sign_in, EXP_ONES, FRAC_ZERO};
         end else if (a_zero || b_zero) begin
            spec_res = {sign_in, {(PRECISION-1){1'b0}}};
         end else begin
            special = 1'b0;
         end
      end else begin
         if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res   = QNAN;
            spec_flags = 5'b10000;
         end else if (b_zero) begin
            spec_res   = {sign_in, EXP_ONES, FRAC_ZERO};
            spec_flags = 5'b01000;
         end else if (a_inf) begin
            spec_res = {sign_in, EXP_ONES, FRAC_ZERO};
         end else if (b_inf || a_zero) begin
            spec_res = {sign_in, {(PRECISION-1){1'b0}}};
         end else begin
            special = 1'b0;
         end
      end
   end

   // Rounding and range check; a carry out of the mantissa leaves 1.000..0, so the
   // shifted fraction is taken one bit higher.
   logic                 inc, inexact;
   logic [N:0]           rnd_sum;
   logic [FRAC_W-1:0]    rnd_frac;
   logic signed [SW-1:0] rnd_exp;
   logic [PRECISION-1:0] rnd_res;
   logic [4:0]           rnd_flags;

   always_comb begin
      inc      = grd & (rnd | stk | mant_q[0]);
      inexact  = grd | rnd | stk;
      rnd_sum  = {1'b0, mant_q} + {{N{1'b0}}, inc};
      rnd_frac = rnd_sum[N] ? rnd_sum[FRAC_W:1] : rnd_sum[FRAC_W-1:0];
      rnd_exp  = rnd_sum[N] ? exp_q + ONE_S : exp_q;
      if (rnd_exp >= ALL_ONES_S) begin
         rnd_res   = {sign_q, EXP_ONES, FRAC_ZERO};
         rnd_flags = 5'b00101;
      end else if (rnd_exp <= ZERO_S) begin
         rnd_res   = {sign_q, {(PRECISION-1){1'b0}}};
         rnd_flags = 5'b00011;
      end else begin
         rnd_res   = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
         rnd_flags = {4'b0000, inexact};
      end
   end

   // Control and datapath sequencing; the product register starts with the multiplier
   // in its low half so the shift-add consumes one bit per cycle.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         op_q      <= 1'b0;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         ma_q      <= '0;
         mb_q      <= '0;
         mant_q    <= '0;
         prod      <= '0;
         rem       <= '0;
         quo       <= '0;
         cnt       <= '0;
         grd       <= 1'b0;
         rnd       <= 1'b0;
         stk       <= 1'b0;
         fin_res   <= '0;
         fin_flags <= '0;
         Result    <= '0;
         Flags     <= '0;
         Done      <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  op_q   <= Operation;
                  sign_q <= sign_in;
                  ma_q   <= {1'b1, fa};
                  mb_q   <= {1'b1, fb};
                  prod   <= {{N{1'b0}}, 1'b1, fb};
                  rem    <= {2'b01, fa};
                  quo    <= '0;
                  exp_q  <= Operation ? div_exp : mul_exp;
                  cnt    <= Operation ? CNT_DIV : CNT_MUL;
                  if (special) begin
                     fin_res   <= spec_res;
                     fin_flags <= spec_flags;
                     state     <= FIN;
                  end else begin
                     state <= ITER;
                  end
               end
            end
            ITER: begin
               if (op_q) begin
                  rem <= rem_next;
                  quo <= {quo[QW-2:0], rem_ge};
               end else begin
                  prod <= {mul_sum, prod[N-1:1]};
               end
               if (cnt == '0) state <= NORM;
               else           cnt   <= cnt - CNT_ONE;
            end
            NORM: begin
               if (!op_q) begin
                  if (prod[2*N-1]) begin
                     mant_q <= prod[2*N-1:N];
                     grd    <= prod[N-1];
                     rnd    <= prod[N-2];
                     stk    <= |prod[N-3:0];
                     exp_q  <= exp_q + ONE_S;
                  end else begin
                     mant_q <= prod[2*N-2:N-1];
                     grd    <= prod[N-2];
                     rnd    <= prod[N-3];
                     stk    <= |prod[N-4:0];
                  end
               end else begin
                  if (quo[QW-1]) begin
                     mant_q <= quo[QW-1:2];
                     grd    <= quo[1];
                     rnd    <= quo[0];
                  end else begin
                     mant_q <= quo[QW-2:1];
                     grd    <= quo[0];
                     rnd    <= 1'b0;
                     exp_q  <= exp_q - ONE_S;
                  end
                  stk <= |rem;
               end
               state <= ROUND;
            end
            ROUND: begin
               fin_res   <= rnd_res;
               fin_flags <= rnd_flags;
               state     <= FIN;
            end
            FIN: begin
               Result <= fin_res;
               Flags  <= fin_flags;
               Done   <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_muldiv_seq.sv
// Directed bench for fpu_muldiv_seq: a binary32 instance driven from a vector table plus
// hand sequences, and a half-width instance for the parametrised format.
module tb_fpu_muldiv_seq;

   localparam int LIMIT = 100;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [4:0]  fl;
      int          lat;
   } vec_t;

   logic        clk, rst_n;
   logic        start32, op32, ready32, done32;
   logic [31:0] a32, b32, result32;
   logic [4:0]  flags32;
   logic        start16, op16, ready16, done16;
   logic [15:0] a16, b16, result16;
   logic [4:0]  flags16;

   int   tests_run = 0;
   int   tests_failed = 0;
   vec_t vecs [13];

   fpu_muldiv_seq dut32 (
      .Clk(clk), .Reset_n(rst_n), .Start(start32), .Operation(op32), .A(a32), .B(b32),
      .Ready(ready32), .Result(result32), .Flags(flags32), .Done(done32)
   );

   fpu_muldiv_seq #(.EXP_W(5), .FRAC_W(10)) dut16 (
      .Clk(clk), .Reset_n(rst_n), .Start(start16), .Operation(op16), .A(a16), .B(b16),
      .Ready(ready16), .Result(result16), .Flags(flags16), .Done(done16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Issues one operation from a point away from the clock edge while Ready is high, then
   // reports the result, the accept-to-Done latency (0 on timeout) and whether the unit
   // stayed busy with Done low until completion.
   task automatic applyStimulus(input logic op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [4:0] fl,
                                output int lat, output logic busy_ok);
      start32 = 1'b1; op32 = op; a32 = a; b32 = b;
      @(posedge clk);
      #1;
      start32 = 1'b0; op32 = ~op; a32 = 32'hDEADBEEF; b32 = 32'h12345678;
      busy_ok = !ready32 && !done32;
      lat = 0;
      for (int c = 1; c <= LIMIT; c++) begin
         @(posedge clk);
         #1;
         if (done32) begin
            lat = c;
            break;
         end
         if (ready32) busy_ok = 1'b0;
      end
      res = result32;
      fl  = flags32;
   endtask

   task automatic applyStimulus16(input logic op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] res, output logic [4:0] fl, output int lat);
      start16 = 1'b1; op16 = op; a16 = a; b16 = b;
      @(posedge clk);
      #1;
      start16 = 1'b0; a16 = 16'hFFFF; b16 = 16'h0000;
      lat = 0;
      for (int c = 1; c <= LIMIT; c++) begin
         @(posedge clk);
         #1;
         if (done16) begin
            lat = c;
            break;
         end
      end
      res = result16;
      fl  = flags16;
   endtask

   initial begin
      logic [31:0] res;
      logic [15:0] res16;
      logic [4:0]  fl;
      int          lat, extra_done, not_ready;
      logic        busy_ok;

      vecs[0]  = '{1'b0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 5'b00000, 27};
      vecs[1]  = '{1'b1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29};
      vecs[2]  = '{1'b0, 32'h00000000, 32'h7F800000, 32'h7FC00000, 5'b10000, 1};
      vecs[3]  = '{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b00000, 1};
      vecs[4]  = '{1'b0, 32'h00000001, 32'h40000000, 32'h00000000, 5'b00000, 1};
      vecs[5]  = '{1'b0, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 5'b00101, 27};
      vecs[6]  = '{1'b0, 32'h00800000, 32'h3F000000, 32'h00000000, 5'b00011, 27};
      vecs[7]  = '{1'b0, 32'hBF800000, 32'h3F800000, 32'hBF800000, 5'b00000, 27};
      vecs[8]  = '{1'b1, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29};
      vecs[9]  = '{1'b1, 32'hC0000000, 32'h3F800000, 32'hC0000000, 5'b00000, 29};
      vecs[10] = '{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 1};
      vecs[11] = '{1'b1, 32'h3F800000, 32'h7F800000, 32'h00000000, 5'b00000, 1};
      vecs[12] = '{1'b0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00001, 27};

      rst_n = 1'b1;
      start32 = 1'b0; op32 = 1'b0; a32 = '0; b32 = '0;
      start16 = 1'b0; op16 = 1'b0; a16 = '0; b16 = '0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset_ready", {31'b0, ready32}, 32'd1);
      checkOutput("reset_done", {31'b0, done32}, 32'd0);
      checkOutput("reset_result", result32, 32'h0);
      checkOutput("reset_flags", {27'b0, flags32}, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, fl, lat, busy_ok);
         checkOutput($sformatf("vec%0d_result", i), res, vecs[i].res);
         checkOutput($sformatf("vec%0d_flags", i), {27'b0, fl}, {27'b0, vecs[i].fl});
         checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         checkOutput($sformatf("vec%0d_busy", i), {31'b0, busy_ok}, 32'd1);
      end

      // Back-to-back: the second Start is raised during the Done cycle of the first.
      @(negedge clk);
      applyStimulus(1'b1, 32'h3F800000, 32'h40400000, res, fl, lat, busy_ok);
      checkOutput("b2b_first_result", res, 32'h3EAAAAAB);
      checkOutput("b2b_first_latency", lat, 29);
      checkOutput("b2b_ready_in_done", {31'b0, ready32}, 32'd1);
      applyStimulus(1'b1, 32'h3F800000, 32'h00000000, res, fl, lat, busy_ok);
      checkOutput("b2b_divzero_result", res, 32'h7F800000);
      checkOutput("b2b_divzero_flags", {27'b0, fl}, 32'b01000);
      checkOutput("b2b_divzero_latency", lat, 1);
      checkOutput("b2b_done_single", {31'b0, busy_ok}, 32'd1);

      // Start raised while busy must be neither honoured nor queued.
      @(negedge clk);
      start32 = 1'b1; op32 = 1'b0; a32 = 32'h3FC00000; b32 = 32'h3FC00000;
      @(posedge clk);
      #1 start32 = 1'b0;
      lat = 0;
      for (int c = 1; c <= LIMIT; c++) begin
         @(posedge clk);
         #1;
         if (c == 5) begin
            start32 = 1'b1; a32 = 32'h40000000; b32 = 32'h40000000;
         end else begin
            start32 = 1'b0;
         end
         if (done32) begin
            lat = c;
            break;
         end
      end
      checkOutput("busy_start_result", result32, 32'h40100000);
      checkOutput("busy_start_latency", lat, 27);
      extra_done = 0; not_ready = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (done32) extra_done++;
         if (!ready32) not_ready++;
      end
      checkOutput("busy_start_not_queued", extra_done, 0);
      checkOutput("busy_start_ready_held", not_ready, 0);

      // Reset mid-multiply aborts with no Done and restores reset outputs at once.
      @(negedge clk);
      start32 = 1'b1; op32 = 1'b0; a32 = 32'h3FC00000; b32 = 32'h3FC00000;
      @(posedge clk);
      #1 start32 = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort_ready", {31'b0, ready32}, 32'd1);
      checkOutput("abort_result", result32, 32'h0);
      checkOutput("abort_flags", {27'b0, flags32}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      extra_done = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (done32) extra_done++;
      end
      checkOutput("abort_no_done", extra_done, 0);
      @(negedge clk);
      applyStimulus(1'b0, 32'h3FC00000, 32'h3FC00000, res, fl, lat, busy_ok);
      checkOutput("after_abort_result", res, 32'h40100000);
      checkOutput("after_abort_flags", {27'b0, fl}, 32'h0);
      checkOutput("after_abort_latency", lat, 27);

      // Half-width format: 1.5*1.5 and 1/3.
      @(negedge clk);
      applyStimulus16(1'b0, 16'h3E00, 16'h3E00, res16, fl, lat);
      checkOutput("half_mul_result", {16'b0, res16}, 32'h4080);
      checkOutput("half_mul_flags", {27'b0, fl}, 32'h0);
      checkOutput("half_mul_latency", lat, 14);
      @(negedge clk);
      applyStimulus16(1'b1, 16'h3C00, 16'h4200, res16, fl, lat);
      checkOutput("half_div_result", {16'b0, res16}, 32'h3555);
      checkOutput("half_div_flags", {27'b0, fl}, 32'b00001);
      checkOutput("half_div_latency", lat, 16);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
